// File: rtl/event_capture_8ch.sv
`default_nettype none
// ============================================================================
//  Module      : event_capture_8ch
//  Description : Upstream request stage for the 8-to-3 encoder path.
//                Synchronizes eight asynchronous request lines, turns rising
//                edges into pending events and serializes them as 3-bit
//                channel codes over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SYNC_STAGES : synchronizer flops per input bit (2..3)
//    RR_MODE     : 0 = fixed priority (highest index), 1 = round-robin
//  Ports
//    clk      in   1  rising-edge clock
//    rst      in   1  asynchronous active-high reset
//    d        in   8  raw request lines, asynchronous to clk
//    code     out  3  index of the presented channel
//    valid    out  1  code is valid
//    ready    in   1  downstream accepts code
//    pending  out  8  registered pending-event vector
//    overflow out  1  sticky: event on a channel that was already pending
//    clr_ovf  in   1  synchronous clear for overflow
// ============================================================================
module event_capture_8ch #(
    parameter int SYNC_STAGES = 2,
    parameter bit RR_MODE     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       overflow,
    input  logic       clr_ovf
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]                  r_hist;
    logic [7:0]                  r_pending;
    logic                        r_ovf;
    logic [2:0]                  r_code;
    logic [2:0]                  r_last;
    state_t                      r_state;

    logic [7:0] w_sync_out;
    logic [7:0] w_rise;
    logic       w_accept;
    logic [7:0] w_acc_mask;
    logic [7:0] w_rem;
    logic [7:0] w_pending_next;
    logic       w_ovf_hit;
    state_t     w_state_next;
    logic [2:0] w_code_next;
    logic [2:0] w_last_next;

    // Channel selection. In round-robin mode the search starts just after
    // ptr and wraps; iterating from the farthest candidate down to the
    // nearest lets the nearest set bit win.
    function automatic logic [2:0] f_select(input logic [7:0] vec,
                                            input logic [2:0] ptr);
        logic [2:0] sel;
        logic [2:0] idx;
        sel = 3'd0;
        idx = 3'd0;
        if (RR_MODE) begin
            for (int k = 8; k >= 1; k--) begin
                idx = ptr + k[2:0];
                if (vec[idx]) begin
                    sel = idx;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) begin
                    sel = 3'(i);
                end
            end
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Synchronizer chain and edge-detect history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 8'd0;
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= w_sync_out;
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_hist;

    // ------------------------------------------------------------------
    // Pending events and overflow
    // ------------------------------------------------------------------
    assign w_accept       = (r_state == ST_PRESENT) & ready;
    assign w_acc_mask     = w_accept ? (8'd1 << r_code) : 8'd0;
    assign w_rem          = r_pending & ~w_acc_mask;
    // A rise coinciding with an accept of the same bit re-arms it as a new
    // event rather than being swallowed by the accept.
    assign w_pending_next = w_rise | w_rem;
    assign w_ovf_hit      = |(w_rise & r_pending & ~w_acc_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 8'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= 3'd0;
            r_last  <= 3'd7;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_code_next  = f_select(r_pending, r_last);
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ready) begin
                    w_last_next = r_code;
                    // Rises landing in this cycle are not part of w_rem;
                    // they are picked up from pending on a later cycle.
                    if (|w_rem) begin
                        w_code_next = f_select(w_rem, r_code);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign code     = r_code;
    assign valid    = (r_state == ST_PRESENT);
    assign pending  = r_pending;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/event_capture_8ch.md
Name: event_capture_8ch

Overview:
- Upstream request stage for the 8-to-3 encoder path.
- Takes 8 raw asynchronous request lines and synchronizes each one.
- Detects rising edges and latches them as pending events.
- Serializes pending events as 3-bit channel codes over a valid/ready handshake, so no event is lost when several lines fire together.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input bit; legal values 2..3.
RR_MODE, 0, selection policy: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
d  input  8  raw request lines; d[i] is channel i; asynchronous to clk.
code  output  3  binary index of the presented channel.
valid  output  1  code is valid.
ready  input  1  downstream accepts code.
pending  output  8  registered pending-event vector.
overflow  output  1  sticky flag: an event arrived on a channel that was already pending.
clr_ovf  input  1  synchronous clear for overflow.

Behaviour:
- Reset: clk and rst as above; reset is asynchronous and active-high.
  - Asserting rst immediately clears the synchronizer chains, the edge-detect history, pending, code, valid and overflow to 0.
  - The round-robin pointer last resets to 7.
  - Events in flight during reset are discarded.
  - After reset release, a line already held high counts as one rising edge.
- Synchronizer: each d[i] passes through SYNC_STAGES flops, giving s[i]. Every other use of d goes through s.
- Edge detect: a history register h stores s each cycle. rise = s & ~h.
- Pending, per bit i:
  - acc_i = valid & ready & (code == i).
  - Next value: pending[i] = rise[i] | (pending[i] & ~acc_i). A rise in the same cycle as an accept of the same bit keeps the bit set, as a new event.
- Overflow: sets when rise[i] & pending[i] & ~acc_i for any i.
  - Cleared by clr_ovf.
  - Set wins over clear in the same cycle.
- Output FSM, states IDLE and PRESENT:
  - IDLE: valid = 0. If the registered pending != 0, load code = select(pending), set valid = 1 and go to PRESENT on the next edge.
  - PRESENT: code and valid hold stable while ready = 0.
  - On accept, compute rem = pending with the accepted bit cleared.
    - If rem != 0: load code = select(rem) on the same edge, valid stays 1, stay in PRESENT (back-to-back, one code per cycle).
    - Else: valid = 0 and go to IDLE.
  - Events that arrive in the accept cycle are seen the following cycle.
- select():
  - RR_MODE = 0: highest set index.
  - RR_MODE = 1: first set index searching last+1, last+2, … modulo 8. On each accept, last = accepted code.
- Latency: d[i] is first sampled high at edge E.
  - s[i] is high after edge E + SYNC_STAGES − 1.
  - pending[i] is set at edge E + SYNC_STAGES.
  - valid rises at edge E + SYNC_STAGES + 1 if the FSM was in IDLE.
  - For SYNC_STAGES = 2: pending at E+2, valid at E+3.
- A level held high produces exactly one event. A new event needs the line to go low for at least one synchronized cycle.
- Pulses shorter than one clock period may be missed. Capturing them is not required.

Test Plan:
- SYNC_STAGES=2, RR_MODE=0: raise d[5] at edge E with ready=1 → pending=8'h20 at E+2; valid=1, code=5 at E+3; pending=0 and valid=0 at E+4.
- RR_MODE=0, ready=0: raise d[1], d[6], d[3] together, then ready=1 → codes presented in order 6, 3, 1 on consecutive cycles; valid drops afterwards; overflow=0.
- RR_MODE=1: d[7] and d[0] pending, last=7 after reset → code 0 then 7. Re-trigger d[0] and d[7] → code 0 then 7 again (pointer wrap).
- ready=0 while code=2 pending: pulse d[2] low then high → overflow=1, pending[2] stays 1. clr_ovf=1 with no new collision → overflow=0 next cycle.
- Accept of code 4 in the same cycle as a new rise[4] → pending[4] stays 1; code 4 re-presented; overflow=0.
- Assert rst while valid=1 and pending=8'hA5 → all outputs 0 immediately, without a clock. d[0] held high through reset → after release, one event with code=0.
